// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Used by the storage top, the clear engine, and the decode stage that addresses the lanes.
package regfile_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 32;

    // Bit offset of lane 'lane' inside a packed bus whose lanes are 'w' bits wide.
    function automatic int lane_sel(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Sequential clear engine: zeroes one storage entry per cycle and flags busy while running.
//   state   | meaning
//   S_IDLE  | storage usable, waiting for clr
//   S_CLEAR | writing zero to entry cnt, one entry per cycle
module rf_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                clr_we = 1'b1;
                // A new request restarts the pass so every entry is cleared after it.
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == S_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NR combinational read lanes with write bypass,
// optional hardwired-zero entry 0 and a sequential clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int AW      = $clog2(DEPTH),
    parameter int NR      = 2,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             busy,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [DW-1:0]    wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [DW-1:0]    wdata1,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [0:DEPTH-1];
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_ok0, wr_ok1;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZERO_R0 && (a == '0);
    endfunction

    rf_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_ok0 = we0 && in_range(waddr0) && !is_zero_reg(waddr0);
    assign wr_ok1 = we1 && in_range(waddr1) && !is_zero_reg(waddr1);

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (busy) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end
        end else begin
            if (wr_ok0) begin
                mem[waddr0] <= wdata0;
            end
            if (wr_ok1) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_lane
        localparam int ALO = lane_sel(k, AW);
        localparam int DLO = lane_sel(k, DW);

        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        assign ra = raddr[ALO +: AW];

        always_comb begin
            rd = '0;
            if (busy || !in_range(ra) || is_zero_reg(ra)) begin
                rd = '0;
            end else if (BYPASS && we1 && (waddr1 == ra)) begin
                rd = wdata1;
            end else if (BYPASS && we0 && (waddr0 == ra)) begin
                rd = wdata0;
            end else begin
                rd = mem[ra];
            end
        end

        assign rdata[DLO +: DW] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: three register-file configurations share one stimulus stream and are
// compared each cycle against a behavioural array model, plus directed scenario checks.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst, clr, we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic        busy_a, busy_b, busy_c;
    logic [63:0] rdata_a, rdata_b, rdata_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // a: defaults; b: no zero register, no bypass; c: DEPTH=24 (not a power of two)
    regfile_mp #(.DW(32), .DEPTH(32), .NR(2), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_a));

    regfile_mp #(.DW(32), .DEPTH(32), .NR(2), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_b));

    regfile_mp #(.DW(32), .DEPTH(24), .NR(2), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_c),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_c));

    // Reference model: contents per configuration and remaining clear cycles.
    int          depth [3] = '{32, 32, 24};
    bit          zr    [3] = '{1'b1, 1'b0, 1'b1};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mm    [3][32];
    int          rem   [3];

    function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
        if (rem[d] > 0) return 32'h0;
        if (int'(a) >= depth[d]) return 32'h0;
        if (zr[d] && a == 5'd0) return 32'h0;
        if (byp[d] && we1 && waddr1 == a) return wdata1;
        if (byp[d] && we0 && waddr0 == a) return wdata0;
        return mm[d][a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic sample();
        logic        bz;
        logic [63:0] rd;
        logic [4:0]  ra;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            bz = (d == 0) ? busy_a : (d == 1) ? busy_b : busy_c;
            rd = (d == 0) ? rdata_a : (d == 1) ? rdata_b : rdata_c;
            chk($sformatf("busy[%0d]", d), {31'h0, bz}, {31'h0, rem[d] > 0});
            for (int k = 0; k < 2; k++) begin
                ra = raddr[k*5 +: 5];
                chk($sformatf("rdata[%0d] lane%0d addr%0d", d, k, ra),
                    rd[k*32 +: 32], exp_rd(d, ra));
            end
        end
    endtask

    task automatic zero_model(input int d);
        for (int i = 0; i < 32; i++) mm[d][i] = 32'h0;
    endtask

    task automatic commit();
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                rem[d] = depth[d];
                zero_model(d);
            end else if (rem[d] > 0) begin
                rem[d] = clr ? depth[d] : rem[d] - 1;
            end else begin
                if (we0 && int'(waddr0) < depth[d] && !(zr[d] && waddr0 == 5'd0))
                    mm[d][waddr0] = wdata0;
                if (we1 && int'(waddr1) < depth[d] && !(zr[d] && waddr1 == 5'd0))
                    mm[d][waddr1] = wdata1;
                if (clr) begin
                    rem[d] = depth[d];
                    zero_model(d);
                end
            end
        end
        #1;
    endtask

    task automatic tick();
        sample();
        commit();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; clr = 1'b0; we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        int n_a, n_b, n_c;
        for (int d = 0; d < 3; d++) begin
            zero_model(d);
            rem[d] = 0;
        end
        idle_inputs();
        raddr = '0;

        // Reset, then a full clear pass with clr low
        rst = 1'b1;
        @(negedge clk);
        commit();
        rst = 1'b0;
        n_a = 0; n_c = 0;
        for (int i = 0; i < 40; i++) begin
            raddr = 10'($urandom_range(0, 1023));
            sample();
            if (busy_a) n_a++;
            if (busy_c) n_c++;
            commit();
        end
        chk("busy_cycles_32", 32'(n_a), 32'd32);
        chk("busy_cycles_24", 32'(n_c), 32'd24);

        // Same-cycle bypass, then storage read
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
        sample();
        chk("bypass_w0", rdata_a[31:0], 32'hDEADBEEF);
        commit();
        idle_inputs();
        sample();
        chk("stored_w0", rdata_a[31:0], 32'hDEADBEEF);
        chk("stored_w0_nobyp", rdata_b[31:0], 32'hDEADBEEF);
        commit();

        // Dual write collision: port 1 wins
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr = {5'd7, 5'd7};
        sample();
        chk("collide_bypass", rdata_a[63:32], 32'h22);
        commit();
        idle_inputs();
        sample();
        chk("collide_store", rdata_a[31:0], 32'h22);
        commit();

        // Entry 0: hardwired zero vs ordinary entry without bypass
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF; raddr = {5'd0, 5'd0};
        sample();
        chk("r0_zero_same", rdata_a[31:0], 32'h0);
        chk("r0_nobyp_old", rdata_b[31:0], 32'h0);
        commit();
        idle_inputs();
        sample();
        chk("r0_zero_after", rdata_a[31:0], 32'h0);
        chk("r0_plain_after", rdata_b[31:0], 32'hFFFF);
        commit();

        // Load, clear, writes ignored while busy
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5; raddr = {5'd3, 5'd3};
        tick();
        idle_inputs();
        clr = 1'b1;
        sample();
        chk("pre_clear", rdata_a[31:0], 32'hA5);
        commit();
        clr = 1'b0;
        n_a = 0;
        for (int i = 0; i < 36; i++) begin
            we0 = (i < 20); waddr0 = 5'd3; wdata0 = 32'h5A;
            sample();
            if (busy_a) n_a++;
            commit();
        end
        idle_inputs();
        chk("clr_busy_32", 32'(n_a), 32'd32);
        sample();
        chk("after_clear", rdata_a[31:0], 32'h0);
        commit();

        // Out-of-range write, rst mid-clear, clr mid-clear
        we0 = 1'b1; waddr0 = 5'd30; wdata0 = 32'hCAFE0030; raddr = {5'd30, 5'd30};
        tick();
        idle_inputs();
        sample();
        chk("oor_dropped", rdata_c[31:0], 32'h0);
        commit();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_c = 0; n_b = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (busy_c) n_c++;
            if (busy_b) n_b++;
            commit();
        end
        chk("restart_busy_24", 32'(n_c), 32'd24);
        chk("restart_busy_32", 32'(n_b), 32'd32);
        raddr = {5'd30, 5'd30};
        sample();
        chk("oor_after", rdata_c[31:0], 32'h0);
        commit();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            clr    = ($urandom_range(0, 59) == 0);
            we0    = $urandom_range(0, 1) == 1;
            we1    = $urandom_range(0, 2) == 0;
            waddr0 = 5'($urandom_range(0, 31));
            waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
            wdata0 = $urandom;
            wdata1 = $urandom;
            raddr  = ($urandom_range(0, 2) == 0) ? {waddr1, waddr0} : 10'($urandom_range(0, 1023));
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
